// File: rtl/imem_pipelined.sv
// imem_pipelined: registered-read instruction memory with req/gnt/rvalid fetch port.
// Optional IMEM_PARITY_EN stores and checks one even-parity bit per word.
module imem_pipelined #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = "instructions.mem"
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                gnt_o,
    input  logic                flush_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    output logic                werr_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  r_mem [DEPTH];

    logic [IDX_W-1:0]  w_ridx;
    logic [IDX_W-1:0]  w_widx;
    logic              w_rfault;
    logic              w_wbad;
    logic              w_fire;
    logic              w_wr;
    logic [DATA_W-1:0] w_merged;

    logic              r_v1;
    logic [DATA_W-1:0] r_d1;
    logic              r_e1;
    logic              r_werr;
    logic              w_vout;
    logic [DATA_W-1:0] w_dout;
    logic              w_eout;

    // Address decode: word index, misalignment and range faults.
    assign w_ridx   = addr_i[IDX_W+1:2];
    assign w_widx   = waddr_i[IDX_W+1:2];
    assign w_rfault = (addr_i[1:0] != 2'b00)
                    | (|addr_i[ADDR_W-1:IDX_W+2]);
    assign w_wbad   = (waddr_i[1:0] != 2'b00)
                    | (|waddr_i[ADDR_W-1:IDX_W+2]);

    // Writes win the cycle; fetches are never granted in reset.
    assign gnt_o  = req_i & ~we_i & ~rst_i;
    assign w_fire = gnt_o & ~flush_i;
    assign w_wr   = we_i & ~rst_i & ~w_wbad;

    // Byte-lane merge of write data over the current word.
    always_comb begin
        w_merged = r_mem[w_widx][DATA_W-1:0];
        for (int k = 0; k < BE_W; k++) begin
            if (wbe_i[k])
                w_merged[8*k +: 8] = wdata_i[8*k +: 8];
        end
    end

    // Array write port.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
`ifdef IMEM_PARITY_EN
            r_mem[w_widx] <= {^w_merged, w_merged};
`else
            r_mem[w_widx] <= w_merged;
`endif
        end
    end

    // Rejected-write flag, one cycle after the attempt.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_werr <= 1'b0;
        else
            r_werr <= we_i & w_wbad;
    end

    // First read stage: capture fault or word at the grant edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_e1 <= 1'b0;
        end else begin
            r_v1 <= w_fire;
            if (w_fire) begin
                if (w_rfault) begin
                    r_d1 <= '0;
                    r_e1 <= 1'b1;
                end else begin
                    r_d1 <= r_mem[w_ridx][DATA_W-1:0];
`ifdef IMEM_PARITY_EN
                    r_e1 <= ^r_mem[w_ridx];
`else
                    r_e1 <= 1'b0;
`endif
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              r_v2;
        logic [DATA_W-1:0] r_d2;
        logic              r_e2;

        // Extra output register stage; flush drops its valid too.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
                r_e2 <= 1'b0;
            end else begin
                r_v2 <= r_v1 & ~flush_i;
                if (r_v1 & ~flush_i) begin
                    r_d2 <= r_d1;
                    r_e2 <= r_e1;
                end
            end
        end

        assign w_vout = r_v2;
        assign w_dout = r_d2;
        assign w_eout = r_e2;
    end else if (READ_LAT == 1) begin : g_lat1
        assign w_vout = r_v1;
        assign w_dout = r_d1;
        assign w_eout = r_e1;
    end else begin : g_bad_lat
        $error("imem_pipelined: READ_LAT must be 1 or 2");
    end

    // A response due in a flush or reset cycle is suppressed too.
    assign rvalid_o = w_vout & ~flush_i & ~rst_i;
    assign rdata_o  = w_dout;
    assign err_o    = w_eout;
    assign werr_o   = r_werr;

endmodule

// File: tb/tb_imem_pipelined.sv
// tb_imem_pipelined: vector table plus scoreboard for READ_LAT=1 and READ_LAT=2.
// Both instances see identical stimulus; each has its own response queue.
module tb_imem_pipelined;

    localparam int DEPTH = 16;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        flush;
        logic        rst;
        logic [31:0] xd;
        logic        xe;
        logic        xwerr;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        we = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;

    logic        gnt1, rvalid1, err1, werr1;
    logic        gnt2, rvalid2, err2, werr2;
    logic [31:0] rdata1, rdata2;

    logic [31:0] cur_xd = '0;
    logic        cur_xe = 1'b0;
    logic        cur_xwerr = 1'b0;
    logic        exp_werr = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    vec_t        tbl[18];

    always #5 clk = ~clk;

    imem_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32),
        .READ_LAT(1), .INIT_FILE("")
    ) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
        .gnt_o(gnt1), .flush_i(flush), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .wbe_i(wbe), .werr_o(werr1)
    );

    imem_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32),
        .READ_LAT(2), .INIT_FILE("")
    ) u2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
        .gnt_o(gnt2), .flush_i(flush), .rvalid_o(rvalid2),
        .rdata_o(rdata2), .err_o(err2), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .wbe_i(wbe), .werr_o(werr2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard push: granted, unflushed fetches become expected responses.
    always @(posedge clk) begin
        cyc++;
        if (rst || flush) begin
            q0.delete();
            q1.delete();
        end
        if (req && !we && !rst && !flush) begin
            q0.push_back('{d: cur_xd, e: cur_xe, due: cyc});
            q1.push_back('{d: cur_xd, e: cur_xe, due: cyc + 1});
        end
        exp_werr = !rst && we && cur_xwerr;
    end

    // Mid-cycle monitor: grant, write error and response checks.
    always @(negedge clk) begin
        logic v0, v1;
        chk("gnt_lat1", {31'b0, gnt1}, {31'b0, req && !we && !rst});
        chk("gnt_lat2", {31'b0, gnt2}, {31'b0, req && !we && !rst});
        chk("werr_lat1", {31'b0, werr1}, {31'b0, exp_werr});
        chk("werr_lat2", {31'b0, werr2}, {31'b0, exp_werr});
        v0 = (q0.size() > 0) && (q0[0].due == cyc) && !flush && !rst;
        v1 = (q1.size() > 0) && (q1[0].due == cyc) && !flush && !rst;
        chk("rvalid_lat1", {31'b0, rvalid1}, {31'b0, v0});
        chk("rvalid_lat2", {31'b0, rvalid2}, {31'b0, v1});
        if (v0) begin
            chk("rdata_lat1", rdata1, q0[0].d);
            chk("err_lat1", {31'b0, err1}, {31'b0, q0[0].e});
            void'(q0.pop_front());
        end
        if (v1) begin
            chk("rdata_lat2", rdata2, q1[0].d);
            chk("err_lat2", {31'b0, err2}, {31'b0, q1[0].e});
            void'(q1.pop_front());
        end
    end

    function automatic vec_t idle();
        vec_t v;
        v = '{req: 1'b0, addr: 32'h0, we: 1'b0, waddr: 32'h0,
              wdata: 32'h0, wbe: 4'h0, flush: 1'b0, rst: 1'b0,
              xd: 32'h0, xe: 1'b0, xwerr: 1'b0};
        return v;
    endfunction

    function automatic vec_t fr(input logic [31:0] a, input logic [31:0] d,
                                input logic e);
        vec_t v;
        v = idle();
        v.req = 1'b1;
        v.addr = a;
        v.xd = d;
        v.xe = e;
        return v;
    endfunction

    function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic bad);
        vec_t v;
        v = idle();
        v.we = 1'b1;
        v.waddr = a;
        v.wdata = d;
        v.wbe = be;
        v.xwerr = bad;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        req = v.req;
        addr = v.addr;
        we = v.we;
        waddr = v.waddr;
        wdata = v.wdata;
        wbe = v.wbe;
        flush = v.flush;
        rst = v.rst;
        cur_xd = v.xd;
        cur_xe = v.xe;
        cur_xwerr = v.xwerr;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = wr(32'h00, 32'h00000013, 4'hF, 1'b0);
        tbl[1]  = wr(32'h04, 32'h00500093, 4'hF, 1'b0);
        tbl[2]  = wr(32'h08, 32'h11223344, 4'hF, 1'b0);
        tbl[3]  = wr(32'h3C, 32'hCAFEF00D, 4'hF, 1'b0);
        tbl[4]  = fr(32'h00, 32'h00000013, 1'b0);
        tbl[5]  = fr(32'h04, 32'h00500093, 1'b0);
        tbl[6]  = wr(32'h08, 32'hDEADBEEF, 4'b0011, 1'b0);
        tbl[6].req = 1'b1;
        tbl[7]  = fr(32'h08, 32'h1122BEEF, 1'b0);
        tbl[8]  = fr(32'h02, 32'h0, 1'b1);
        tbl[9]  = fr(DEPTH * 4, 32'h0, 1'b1);
        tbl[10] = wr(32'h06, 32'hFFFFFFFF, 4'hF, 1'b1);
        tbl[11] = wr(DEPTH * 4, 32'hFFFFFFFF, 4'hF, 1'b1);
        tbl[12] = fr(32'h04, 32'h00500093, 1'b0);
        tbl[13] = wr(32'h08, 32'hAABBCCDD, 4'b1100, 1'b0);
        tbl[14] = fr(32'h08, 32'hAABBBEEF, 1'b0);
        tbl[15] = fr(32'h3C, 32'hCAFEF00D, 1'b0);
        tbl[16] = fr(32'h3E, 32'h0, 1'b1);
        tbl[17] = idle();

        v = idle();
        v.rst = 1'b1;
        apply(v);
        apply(v);
        apply(idle());
        @(negedge clk);
        chk("reset_rdata_lat1", rdata1, 32'h0);
        chk("reset_rdata_lat2", rdata2, 32'h0);
        chk("reset_err_lat1", {31'b0, err1}, 32'h0);
        chk("reset_err_lat2", {31'b0, err2}, 32'h0);

        for (int i = 0; i < 18; i++)
            apply(tbl[i]);

        // Flush on the third of three back-to-back fetches.
        apply(fr(32'h00, 32'h00000013, 1'b0));
        apply(fr(32'h04, 32'h00500093, 1'b0));
        v = fr(32'h08, 32'hAABBBEEF, 1'b0);
        v.flush = 1'b1;
        apply(v);
        apply(fr(32'h04, 32'h00500093, 1'b0));
        apply(idle());
        apply(idle());
        apply(idle());

        // Reset with two fetches in flight and a write pending.
        apply(fr(32'h00, 32'h00000013, 1'b0));
        apply(fr(32'h04, 32'h00500093, 1'b0));
        v = wr(32'h00, 32'hFFFFFFFF, 4'hF, 1'b0);
        v.rst = 1'b1;
        apply(v);
        apply(idle());
        @(negedge clk);
        chk("midrst_rdata_lat1", rdata1, 32'h0);
        chk("midrst_rdata_lat2", rdata2, 32'h0);
        apply(fr(32'h00, 32'h00000013, 1'b0));
        apply(fr(32'h04, 32'h00500093, 1'b0));
        apply(idle());

`ifdef IMEM_PARITY_EN
        // Corrupt one stored bit; raw data returns with err set.
        @(posedge clk);
        u1.r_mem[1] = u1.r_mem[1] ^ 33'h20;
        u2.r_mem[1] = u2.r_mem[1] ^ 33'h20;
        apply(fr(32'h04, 32'h005000B3, 1'b1));
        apply(idle());
`endif

        for (int k = 0; k < 6; k++) begin
            if (q0.size() == 0 && q1.size() == 0)
                break;
            apply(idle());
        end
        apply(idle());
        @(negedge clk);
        chk("drain_pending", q0.size() + q1.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
